// File: rtl/decode_stage_pkg.sv
// Shared opcode, write-back select and bundle definitions for the decode stage.
// DECODE_ILLEGAL_TRAP_EN adds an illegal-opcode flag to the decoded bundle.
package decode_stage_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYS      = 7'b1110011;

  localparam logic [2:0] WB_NONE = 3'd0;
  localparam logic [2:0] WB_ALU  = 3'd1;
  localparam logic [2:0] WB_MEM  = 3'd2;
  localparam logic [2:0] WB_PC4  = 3'd3;
  localparam logic [2:0] WB_SYS  = 3'd4;

  localparam logic MEM_REQ_READ  = 1'b0;
  localparam logic MEM_REQ_WRITE = 1'b1;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  typedef enum logic [2:0] {FmtNone, FmtI, FmtS, FmtB, FmtU, FmtJ} imm_fmt_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       reg_write_en;
    logic [2:0] wb_sel;
    logic       mem_req;
    logic       mem_req_write;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic       illegal;
`endif
  } ctrl_t;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    case (op)
      OP_OP_IMM, OP_LOAD, OP_JALR, OP_SYS: imm_fmt = FmtI;
      OP_STORE:                            imm_fmt = FmtS;
      OP_BRANCH:                           imm_fmt = FmtB;
      OP_LUI, OP_AUIPC:                    imm_fmt = FmtU;
      OP_JAL:                              imm_fmt = FmtJ;
      OP_MISC_MEM:                         imm_fmt = FmtNone;
      default:                             imm_fmt = FmtNone;
    endcase
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational RV32I field, immediate and control decode.
// DECODE_ILLEGAL_TRAP_EN flags opcodes outside the base set as illegal.
module decode_fields
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     i_inst,
  output ctrl_t           o_ctrl,
  output logic [XLEN-1:0] o_imm
);

  logic        [6:0]  w_op;
  logic signed [31:0] w_imm32;

  assign w_op = i_inst[6:0];

  always_comb begin
    w_imm32 = '0;
    case (imm_fmt(w_op))
      FmtI: w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      FmtS: w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      FmtB: w_imm32 = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      FmtU: w_imm32 = {i_inst[31:12], 12'b0};
      FmtJ: w_imm32 = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Signed cast so RV64 builds sign-extend the 32-bit immediate.
  assign o_imm = XLEN'(w_imm32);

  always_comb begin
    o_ctrl               = '0;
    o_ctrl.rs1           = i_inst[19:15];
    o_ctrl.rs2           = i_inst[24:20];
    o_ctrl.rd            = i_inst[11:7];
    o_ctrl.opcode        = w_op;
    o_ctrl.funct3        = i_inst[14:12];
    o_ctrl.funct7        = i_inst[31:25];
    o_ctrl.wb_sel        = WB_NONE;
    o_ctrl.mem_req_write = MEM_REQ_READ;
    case (w_op)
      OP_OP, OP_OP_IMM, OP_LUI, OP_AUIPC: begin
        o_ctrl.reg_write_en = 1'b1;
        o_ctrl.wb_sel       = WB_ALU;
      end
      OP_LOAD: begin
        o_ctrl.reg_write_en = 1'b1;
        o_ctrl.wb_sel       = WB_MEM;
        o_ctrl.mem_req      = 1'b1;
      end
      OP_STORE: begin
        o_ctrl.mem_req       = 1'b1;
        o_ctrl.mem_req_write = MEM_REQ_WRITE;
      end
      OP_JAL, OP_JALR: begin
        o_ctrl.reg_write_en = 1'b1;
        o_ctrl.wb_sel       = WB_PC4;
      end
      OP_SYS: begin
        o_ctrl.reg_write_en = 1'b1;
        o_ctrl.wb_sel       = WB_SYS;
      end
      OP_BRANCH, OP_MISC_MEM: ;
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        o_ctrl.illegal = 1'b1;
`endif
      end
    endcase
    if (o_ctrl.rd == 5'd0) o_ctrl.reg_write_en = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Two-entry (output + skid) RV32I decode pipeline stage with a handoff counter.
// DECODE_ILLEGAL_TRAP_EN adds the out_illegal port.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_reg_write_en,
  output logic [2:0]       out_wb_sel,
  output logic             out_mem_req,
  output logic             out_mem_req_write,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic             out_illegal,
`endif
  output logic [CNT_W-1:0] decoded_count
);

  state_e            r_state, w_state_d;
  logic              r_in_ready;
  ctrl_t             r_out_ctrl, r_skid_ctrl, w_dec_ctrl;
  logic [XLEN-1:0]   r_out_pc, r_skid_pc, r_out_imm, r_skid_imm, w_dec_imm;
  logic [CNT_W-1:0]  r_count;
  logic              w_in_fire, w_out_fire;
  logic              w_load_out_in, w_load_out_skid, w_load_skid;

  decode_fields #(.XLEN(XLEN)) u_fields (
    .i_inst (in_inst),
    .o_ctrl (w_dec_ctrl),
    .o_imm  (w_dec_imm)
  );

  assign out_valid  = (r_state != StEmpty);
  assign in_ready   = r_in_ready;
  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_comb begin
    w_state_d       = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    unique case (r_state)
      StEmpty: if (w_in_fire) begin
        w_state_d     = StOne;
        w_load_out_in = 1'b1;
      end
      StOne: begin
        if (w_in_fire && w_out_fire) begin
          w_load_out_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_d   = StTwo;
          w_load_skid = 1'b1;
        end else if (w_out_fire) begin
          w_state_d = StEmpty;
        end
      end
      StTwo: if (w_out_fire) begin
        w_state_d       = StOne;
        w_load_out_skid = 1'b1;
      end
      default: w_state_d = StEmpty;
    endcase
    if (flush) begin
      w_state_d       = StEmpty;
      w_load_out_in   = 1'b0;
      w_load_out_skid = 1'b0;
      w_load_skid     = 1'b0;
    end
  end

  // in_ready comes from a flop so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StEmpty;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_in_ready <= (w_state_d != StTwo);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_ctrl  <= '0;
      r_out_pc    <= '0;
      r_out_imm   <= '0;
      r_skid_ctrl <= '0;
      r_skid_pc   <= '0;
      r_skid_imm  <= '0;
    end else begin
      if (w_load_out_in) begin
        r_out_ctrl <= w_dec_ctrl;
        r_out_pc   <= in_pc;
        r_out_imm  <= w_dec_imm;
      end else if (w_load_out_skid) begin
        r_out_ctrl <= r_skid_ctrl;
        r_out_pc   <= r_skid_pc;
        r_out_imm  <= r_skid_imm;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= w_dec_ctrl;
        r_skid_pc   <= in_pc;
        r_skid_imm  <= w_dec_imm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_out_fire && !flush) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign decoded_count     = r_count;
  assign out_pc            = r_out_pc;
  assign out_imm           = r_out_imm;
  assign out_rs1           = r_out_ctrl.rs1;
  assign out_rs2           = r_out_ctrl.rs2;
  assign out_rd            = r_out_ctrl.rd;
  assign out_opcode        = r_out_ctrl.opcode;
  assign out_funct3        = r_out_ctrl.funct3;
  assign out_funct7        = r_out_ctrl.funct7;
  assign out_reg_write_en  = r_out_ctrl.reg_write_en;
  assign out_wb_sel        = r_out_ctrl.wb_sel;
  assign out_mem_req       = r_out_ctrl.mem_req;
  assign out_mem_req_write = r_out_ctrl.mem_req_write;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign out_illegal       = r_out_ctrl.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Randomised bench for decode_stage against a queue-based reference model.
module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk, reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_pc, out_pc, out_imm;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  logic [6:0]       out_opcode, out_funct7;
  logic [2:0]       out_funct3, out_wb_sel;
  logic             out_reg_write_en, out_mem_req, out_mem_req_write;
  logic [CNT_W-1:0] decoded_count;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic             out_illegal;
`endif

  decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_inst           (in_inst),
    .in_pc             (in_pc),
    .flush             (flush),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pc            (out_pc),
    .out_rs1           (out_rs1),
    .out_rs2           (out_rs2),
    .out_rd            (out_rd),
    .out_opcode        (out_opcode),
    .out_funct3        (out_funct3),
    .out_funct7        (out_funct7),
    .out_imm           (out_imm),
    .out_reg_write_en  (out_reg_write_en),
    .out_wb_sel        (out_wb_sel),
    .out_mem_req       (out_mem_req),
    .out_mem_req_write (out_mem_req_write),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .out_illegal       (out_illegal),
`endif
    .decoded_count     (decoded_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3, wb;
    logic [31:0] imm;
    logic        we, mr, mw, ill;
  } exp_t;

  exp_t        q[$];
  int unsigned m_cnt;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [6:0]  ops[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33,
                           7'h0F, 7'h73};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    exp_t       e;
    longint     v;
    logic [6:0] op;
    op = inst[6:0];
    e.pc = pc; e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7];
    e.opcode = op; e.f3 = inst[14:12]; e.f7 = inst[31:25];
    e.we = 1'b0; e.wb = 3'd0; e.mr = 1'b0; e.mw = 1'b0; e.ill = 1'b0;
    v = 0;
    case (op)
      7'h13, 7'h03, 7'h67, 7'h73: begin
        v = longint'(inst[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        v = longint'(inst[31:25]) * 32 + longint'(inst[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        v = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
          + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h37, 7'h17: v = longint'(inst[31:12]) * 4096;
      7'h6F: begin
        v = longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096
          + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      default: v = 0;
    endcase
    e.imm = v[31:0];
    case (op)
      7'h33, 7'h13, 7'h37, 7'h17: begin e.we = 1'b1; e.wb = 3'd1; end
      7'h03:        begin e.we = 1'b1; e.wb = 3'd2; e.mr = 1'b1; end
      7'h23:        begin e.mr = 1'b1; e.mw = 1'b1; end
      7'h6F, 7'h67: begin e.we = 1'b1; e.wb = 3'd3; end
      7'h73:        begin e.we = 1'b1; e.wb = 3'd4; end
      7'h63, 7'h0F: ;
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        e.ill = 1'b1;
`endif
      end
    endcase
    if (e.rd == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  task automatic compare();
    exp_t e;
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("decoded_count", 64'(decoded_count), 64'(m_cnt % 16));
    if (q.size() > 0) begin
      e = q[0];
      check("out_pc", 64'(out_pc), 64'(e.pc));
      check("out_rs1", 64'(out_rs1), 64'(e.rs1));
      check("out_rs2", 64'(out_rs2), 64'(e.rs2));
      check("out_rd", 64'(out_rd), 64'(e.rd));
      check("out_opcode", 64'(out_opcode), 64'(e.opcode));
      check("out_funct3", 64'(out_funct3), 64'(e.f3));
      check("out_funct7", 64'(out_funct7), 64'(e.f7));
      check("out_imm", 64'(out_imm), 64'(e.imm));
      check("out_reg_write_en", 64'(out_reg_write_en), 64'(e.we));
      check("out_wb_sel", 64'(out_wb_sel), 64'(e.wb));
      check("out_mem_req", 64'(out_mem_req), 64'(e.mr));
      check("out_mem_req_write", 64'(out_mem_req_write), 64'(e.mw));
`ifdef DECODE_ILLEGAL_TRAP_EN
      check("out_illegal", 64'(out_illegal), 64'(e.ill));
`endif
    end
  endtask

  // Drive one cycle, advance the model on the same handshake rules, then compare.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic acc, cons;
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    acc  = v && (q.size() < 2);
    cons = (q.size() > 0) && ordy;
    if (fl) begin
      q.delete();
    end else begin
      if (cons) begin
        void'(q.pop_front());
        m_cnt++;
      end
      if (acc) q.push_back(ref_decode(inst, pc));
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h40;
    out_ready = 1'b1; flush = 1'b1;
    q.delete();
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_count", 64'(decoded_count), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_out_imm", 64'(out_imm), 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_out_opcode", 64'(out_opcode), 64'd0);
    check("rst_out_we", 64'(out_reg_write_en), 64'd0);
    check("rst_out_wb_sel", 64'(out_wb_sel), 64'd0);
    check("rst_out_mem_req", 64'(out_mem_req), 64'd0);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [31:0] sel;
    r   = $urandom();
    sel = $urandom_range(0, 99);
    if (sel >= 10) r[6:0] = ops[$urandom_range(0, 10)];
    if (sel < 25) r[11:7] = 5'd0;
    return r;
  endfunction

  initial begin
    int unsigned cnt_before;
    reset = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    do_reset();

    // addi x1, x0, 5
    step(1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0);
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_rd", 64'(out_rd), 64'd1);
    check("addi_imm", 64'(out_imm), 64'd5);
    check("addi_wb", 64'(out_wb_sel), 64'd1);
    check("addi_we", 64'(out_reg_write_en), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Back-to-back under backpressure; third offer held until space frees up.
    step(1'b1, 32'h00A00113, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h0000A183, 32'h204, 1'b0, 1'b0);
    check("b2b_in_ready_low", 64'(in_ready), 64'd0);
    step(1'b1, 32'h00C0006F, 32'h208, 1'b0, 1'b0);
    step(1'b1, 32'h00C0006F, 32'h208, 1'b1, 1'b0);
    step(1'b1, 32'h00C0006F, 32'h208, 1'b1, 1'b0);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("b2b_all_emerged", 64'(decoded_count), 64'd4);

    // beq with offset -4
    step(1'b1, 32'hFE000EE3, 32'h300, 1'b0, 1'b0);
    check("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
    check("beq_we", 64'(out_reg_write_en), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush while holding two bundles, with a new offer in the same cycle.
    step(1'b1, 32'h00000013, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 32'h404, 1'b0, 1'b0);
    cnt_before = m_cnt;
    step(1'b1, 32'h00100093, 32'h408, 1'b0, 1'b1);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_count", 64'(decoded_count), 64'(cnt_before % 16));

    // addi x0 never writes; all-ones is unknown / illegal.
    step(1'b1, 32'h00000013, 32'h500, 1'b0, 1'b0);
    check("addi_x0_we", 64'(out_reg_write_en), 64'd0);
    step(1'b1, 32'hFFFFFFFF, 32'h504, 1'b1, 1'b0);
    check("ones_mem_req", 64'(out_mem_req), 64'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("ones_illegal", 64'(out_illegal), 64'd1);
`endif
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) < 70, rand_inst(), $urandom(),
           $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
    end

    // Reset mid-operation, then 17 consumed bundles wrap a 4-bit counter to 1.
    step(1'b1, 32'h00500093, 32'h600, 1'b0, 1'b0);
    step(1'b1, 32'h00500093, 32'h604, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, rand_inst(), 32'h700 + 32'(i) * 4, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("count_wrap", 64'(decoded_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
